// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce array.
package debounce_pkg;

    localparam int DEB_LENGTH_DEFAULT        = 16;
    localparam int DEB_SYNC_DEFAULT          = 2;
    localparam int DEB_REPEAT_DELAY_DEFAULT  = 1 << 22;
    localparam int DEB_REPEAT_PERIOD_DEFAULT = 1 << 20;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability counter, level and edge pulses.
// Auto-repeat hold logic is built only when DEBOUNCE_ARRAY_REPEAT_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   LENGTH        = DEB_LENGTH_DEFAULT,
    parameter int   SYNC_STAGES   = DEB_SYNC_DEFAULT,
    parameter logic INIT_LEVEL    = 1'b0,
    parameter int   REPEAT_DELAY  = DEB_REPEAT_DELAY_DEFAULT,
    parameter int   REPEAT_PERIOD = DEB_REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out,
    output logic down,
    output logic up,
    output logic event_next
);

    logic [SYNC_STAGES-1:0] sync;
    logic [LENGTH-1:0]      count;
    logic                   s;
    logic                   idle;
    logic                   flip;
    logic                   rep;

    assign s          = sync[SYNC_STAGES-1];
    assign idle       = (out == s);
    assign flip       = !idle && (&count);
    assign event_next = flip | rep;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= {SYNC_STAGES{INIT_LEVEL}};
            count <= '0;
            out   <= INIT_LEVEL;
            down  <= 1'b0;
            up    <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], in};
            count <= idle ? '0 : count + 1'b1;
            if (flip) out <= ~out;
            down  <= (flip & ~out) | rep;
            up    <= flip & out;
        end
    end

`ifdef DEBOUNCE_ARRAY_REPEAT_EN
    localparam int HW = clog2(REPEAT_DELAY + 1);

    logic [HW-1:0] hold;
    logic          held;

    assign held = out && idle;
    assign rep  = held && (hold == HW'(REPEAT_DELAY - 1));

    // After the first repeat, rewind so the next one lands a period later.
    always_ff @(posedge clk) begin
        if (!rst_n || !held) begin
            hold <= '0;
        end else if (rep) begin
            hold <= HW'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
            hold <= hold + 1'b1;
        end
    end
`else
    logic unused_repeat;

    assign rep           = 1'b0;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

endmodule

// File: rtl/debounce_array.sv
// N-channel debouncer: per-channel input inversion plus a shared event flag.
// Optional auto-repeat on held inputs via DEBOUNCE_ARRAY_REPEAT_EN.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS      = 4,
    parameter int                  LENGTH        = DEB_LENGTH_DEFAULT,
    parameter int                  SYNC_STAGES   = DEB_SYNC_DEFAULT,
    parameter logic [CHANNELS-1:0] INVERT        = '0,
    parameter logic                INIT_LEVEL    = 1'b0,
    parameter int                  REPEAT_DELAY  = DEB_REPEAT_DELAY_DEFAULT,
    parameter int                  REPEAT_PERIOD = DEB_REPEAT_PERIOD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] down,
    output logic [CHANNELS-1:0] up,
    output logic                any_event
);

    logic [CHANNELS-1:0] ev_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .LENGTH        (LENGTH),
            .SYNC_STAGES   (SYNC_STAGES),
            .INIT_LEVEL    (INIT_LEVEL),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .in         (in[i] ^ INVERT[i]),
            .out        (out[i]),
            .down       (down[i]),
            .up         (up[i]),
            .event_next (ev_next[i])
        );
    end

    // Registered from the same next-state terms so it lines up with the pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_event <= 1'b0;
        end else begin
            any_event <= |ev_next;
        end
    end

endmodule

// File: tb/tb_debounce_array.sv
// Directed self-checking bench for debounce_array (LENGTH=4, SYNC_STAGES=2).
// Repeat expectations follow DEBOUNCE_ARRAY_REPEAT_EN.
module tb_debounce_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] down;
    logic [3:0] up;
    logic       any_event;
    logic [3:0] in_inv;
    logic [3:0] out_inv;
    logic [3:0] down_inv;
    logic [3:0] up_inv;
    logic       any_inv;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    debounce_array #(
        .CHANNELS(4), .LENGTH(4), .SYNC_STAGES(2), .INVERT(4'b0000),
        .INIT_LEVEL(1'b0), .REPEAT_DELAY(40), .REPEAT_PERIOD(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .out(out),
        .down(down), .up(up), .any_event(any_event)
    );

    debounce_array #(
        .CHANNELS(4), .LENGTH(4), .SYNC_STAGES(2), .INVERT(4'b0001),
        .INIT_LEVEL(1'b0), .REPEAT_DELAY(40), .REPEAT_PERIOD(10)
    ) dut_inv (
        .clk(clk), .rst_n(rst_n), .in(in_inv), .out(out_inv),
        .down(down_inv), .up(up_inv), .any_event(any_inv)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int   n_down;
        logic rep_exp;
        logic feat;
`ifdef DEBOUNCE_ARRAY_REPEAT_EN
        feat = 1'b1;
`else
        feat = 1'b0;
`endif
        rst_n  = 1'b0;
        in     = 4'hF;
        in_inv = 4'h0;

        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_out", 32'(out), 0);
            chk("rst_down", 32'(down), 0);
            chk("rst_up", 32'(up), 0);
            chk("rst_any", 32'(any_event), 0);
            chk("rst_inv_out", 32'(out_inv), 0);
        end

        // clean press on ch0; inverted instance sees a press on ch0 too
        rst_n = 1'b1;
        in    = 4'h1;
        for (int e = 1; e <= 17; e++) begin
            tick();
            chk("press_wait_out", 32'(out), 0);
            chk("press_wait_down", 32'(down), 0);
            chk("press_wait_any", 32'(any_event), 0);
            chk("inv_wait_out", 32'(out_inv), 0);
        end
        tick();
        chk("press_out", 32'(out), 32'h1);
        chk("press_down", 32'(down), 32'h1);
        chk("press_up", 32'(up), 0);
        chk("press_any", 32'(any_event), 1);
        chk("inv_out", 32'(out_inv), 32'h1);
        chk("inv_down", 32'(down_inv), 32'h1);
        n_down = 1;

        // hold ch0 for 100 cycles; repeats at 40, 50, 60 ... when enabled
        for (int h = 1; h <= 100; h++) begin
            tick();
            rep_exp = feat && (h >= 40) && ((h - 40) % 10 == 0);
            if (h == 1) chk("inv_down_once", 32'(down_inv), 0);
            chk("hold_down", 32'(down), 32'(rep_exp));
            chk("hold_any", 32'(any_event), 32'(rep_exp));
            chk("hold_up", 32'(up), 0);
            chk("hold_out", 32'(out), 32'h1);
            if (down[0]) n_down++;
        end
        chk("hold_down_count", 32'(n_down), feat ? 32'd8 : 32'd1);

        // release ch0
        in = 4'h0;
        for (int e = 1; e <= 17; e++) begin
            tick();
            chk("rel_wait_out", 32'(out), 32'h1);
            chk("rel_wait_up", 32'(up), 0);
            chk("rel_wait_down", 32'(down), 0);
        end
        tick();
        chk("rel_out", 32'(out), 0);
        chk("rel_up", 32'(up), 32'h1);
        chk("rel_down", 32'(down), 0);
        chk("rel_any", 32'(any_event), 1);

        // bounce on ch1: 5 high / 5 low, six times
        for (int k = 0; k < 6; k++) begin
            in = 4'h2;
            for (int c = 0; c < 5; c++) begin
                tick();
                chk("bounce_out", 32'(out), 0);
                chk("bounce_pulse", 32'({down, up}), 0);
                chk("bounce_any", 32'(any_event), 0);
            end
            in = 4'h0;
            for (int c = 0; c < 5; c++) begin
                tick();
                chk("bounce_out", 32'(out), 0);
                chk("bounce_pulse", 32'({down, up}), 0);
                chk("bounce_any", 32'(any_event), 0);
            end
        end
        in = 4'h2;
        for (int e = 1; e <= 17; e++) begin
            tick();
            chk("settle_wait_out", 32'(out), 0);
            chk("settle_wait_down", 32'(down), 0);
        end
        tick();
        chk("settle_out", 32'(out), 32'h2);
        chk("settle_down", 32'(down), 32'h2);
        chk("settle_any", 32'(any_event), 1);

        in = 4'h0;
        for (int e = 1; e <= 18; e++) tick();
        chk("rel1_up", 32'(up), 32'h2);
        chk("rel1_out", 32'(out), 0);

        // press ch2, then release ch2 and press ch3 together
        in = 4'h4;
        for (int e = 1; e <= 18; e++) tick();
        chk("press2_down", 32'(down), 32'h4);
        chk("press2_out", 32'(out), 32'h4);
        tick();
        chk("press2_after", 32'({down, up, any_event}), 0);

        in = 4'h8;
        for (int e = 1; e <= 17; e++) begin
            tick();
            chk("simul_wait", 32'({down, up, any_event}), 0);
            chk("simul_wait_out", 32'(out), 32'h4);
        end
        tick();
        chk("simul_up", 32'(up), 32'h4);
        chk("simul_down", 32'(down), 32'h8);
        chk("simul_any", 32'(any_event), 1);
        chk("simul_out", 32'(out), 32'h8);
        tick();
        chk("simul_after", 32'({down, up, any_event}), 0);

        // reset mid-debounce on ch0 aborts the change
        in = 4'h9;
        for (int c = 0; c < 10; c++) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_out", 32'(out), 0);
        chk("midrst_pulse", 32'({down, up, any_event}), 0);
        in    = 4'h0;
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            chk("postrst_out", 32'(out), 0);
            chk("postrst_pulse", 32'({down, up, any_event}), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/debounce_array.md
Name: debounce_array

Overview:
- Parameterised N-channel successor to the single-input button debouncer.
- Per channel: synchronises an asynchronous input (button, switch, encoder contact), filters contact bounce with a saturating stability counter, and produces a clean level plus registered press/release pulses.
- Sits between board-level pins and the user-interface FSMs (clock-setting menus, mode buttons).

Parameters:
- CHANNELS, 4, number of independent inputs.
- LENGTH, 16, stability counter width; threshold is 2^LENGTH consecutive disagreeing cycles.
- SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..4.
- INVERT, {CHANNELS{1'b0}}, per-channel mask; set bit inverts the raw input (active-low buttons).
- INIT_LEVEL, 1'b0, reset value of synchroniser stages and out.
- REPEAT_DELAY, 2^22, hold cycles before the first auto-repeat (used only with the optional feature).
- REPEAT_PERIOD, 2^20, cycles between subsequent repeats (used only with the optional feature).

Ports:
- clk  input  1  system clock; sole clock.
- rst_n  input  1  synchronous, active-low reset.
- in  input  CHANNELS  raw asynchronous inputs.
- out  output  CHANNELS  debounced, registered levels.
- down  output  CHANNELS  one-cycle registered pulse on out 0→1 (and on repeats).
- up  output  CHANNELS  one-cycle registered pulse on out 1→0.
- any_event  output  1  registered OR of all down|up bits, same cycle.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - all sync stages = INIT_LEVEL; out = INIT_LEVEL; count = 0.
  - down/up/any_event = 0; repeat state cleared.
  - Reset mid-debounce aborts the pending change; no pulse is emitted.
- Per channel i:
  - x = in[i]^INVERT[i] passes through SYNC_STAGES flops; s = last stage.
  - idle = (out[i]==s).
  - If idle: count <= 0.
  - Else: count <= count+1 (wraps to 0); if count == all-ones, out[i] <= ~out[i].
- Latency: a clean step on in is sampled at edge 1; out flips at edge SYNC_STAGES + 2^LENGTH (edge 18 for SYNC_STAGES=2, LENGTH=4).
- Glitch: any return to agreement before saturation resets count; out does not change.
- Pulses: down[i]/up[i] are registered and high exactly in the first cycle out[i] shows the new value, for one cycle only. down and up are never both high on the same channel.
- Channels are fully independent. Simultaneous events on several channels assert several bits in the same cycle.
- A steady input never produces pulses. No combinational path from in to any output.

Optional Feature:
- Macro DEBOUNCE_ARRAY_REPEAT_EN.
- Defined:
  - Per-channel hold counter runs while out[i]==1 and idle.
  - After REPEAT_DELAY cycles of continuous hold: one extra down[i] pulse. Then one pulse every REPEAT_PERIOD cycles.
  - Counter clears on release, on reset, or whenever out[i]==0.
  - up is unaffected.
  - any_event includes repeat pulses.
- Undefined: no hold counters synthesised; REPEAT_* ignored; down fires only on a real 0→1 transition.

Decomposition:
- Package debounce_pkg:
  - clog2 function for the hold-counter width.
  - Default constants DEB_LENGTH_DEFAULT, DEB_SYNC_DEFAULT, DEB_REPEAT_DELAY_DEFAULT, DEB_REPEAT_PERIOD_DEFAULT.
- Sub-module debounce_channel:
  - Contents: synchroniser, counter, out, down/up registers, optional repeat logic.
  - Instantiated CHANNELS times in a generate loop.
  - Top level holds only the INVERT mapping and the any_event OR/register.

Test Plan (CHANNELS=4, LENGTH=4, SYNC_STAGES=2, INIT_LEVEL=0, REPEAT_DELAY=40, REPEAT_PERIOD=10):
- Reset: hold rst_n=0 3 cycles with in=4'hF → out=0, down=up=any_event=0 throughout.
- Clean press: in[0] 0→1 before edge 1 → out[0]=1 from edge 18; down[0]=1 for exactly cycle 18; any_event=1 same cycle; up=0.
- Bounce: in[1] toggles high/low every 5 cycles for 60 cycles, then stays high → no pulse during the bounce; out[1] rises 18 edges after the final rising sample.
- Simultaneous: in[2] release and in[3] press on the same edge (after both settled) → up[2] and down[3] both high in the same cycle.
- INVERT=4'b0001, in[0] held 0 from reset → out[0]=1 at edge 18; down[0] pulses once.
- Feature on: hold in[0]=1 for 100 cycles after out[0] rises → repeat down[0] at hold cycles 40, 50, 60, …. With the feature off, exactly one down[0] pulse.
